// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pkg
// Shared constants for the write-back stage: write-data source select codes,
// load-type codes and the default write-back PC after reset.
// Configuration macro used by this slice: WB_LOAD_EXT_EN (sub-word load
// extension; when undefined, loaded words pass through unmodified).
// -----------------------------------------------------------------------------
package wb_stage_pkg;

  // Value held in the write-back PC register after reset
  localparam logic [31:0] WB_RESET_PC = 32'h0000_3000;

  // Write-data source select
  localparam logic [1:0] WDSEL_ALU  = 2'b00;
  localparam logic [1:0] WDSEL_MEM  = 2'b01;
  localparam logic [1:0] WDSEL_PC8  = 2'b10;
  localparam logic [1:0] WDSEL_ZERO = 2'b11;

  // Load type; codes above LD_LH behave as a full-word load
  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LBU = 3'b001;
  localparam logic [2:0] LD_LB  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b011;
  localparam logic [2:0] LD_LH  = 3'b100;

endpackage

// File: rtl/wb_stage_load_ext.sv
// -----------------------------------------------------------------------------
// load_ext
// Combinational sub-word load extractor. Selects a byte or halfword from the
// raw memory word using the byte offset and sign- or zero-extends it.
// Only instantiated when WB_LOAD_EXT_EN is defined.
// Ports:
//   i_word   [31:0] raw data-memory word
//   i_offset [1:0]  byte offset of the load address
//   i_type   [2:0]  load type code (see wb_stage_pkg)
//   o_data   [31:0] extended load data
// -----------------------------------------------------------------------------
module load_ext
  import wb_stage_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_type,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte and halfword lane selection from the load offset
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    case (i_offset)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = 8'h00;
    endcase
    // Halfword lane depends on offset bit 1 only; bit 0 is ignored
    if (i_offset[1]) begin
      w_half = i_word[31:16];
    end else begin
      w_half = i_word[15:0];
    end
  end

  // Extension by load type; unknown codes fall back to a full word
  always_comb begin
    o_data = i_word;
    case (i_type)
      LD_LBU:  o_data = {24'h00_0000, w_byte};
      LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      LD_LHU:  o_data = {16'h0000, w_half};
      LD_LH:   o_data = {{16{w_half[15]}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Pipeline write-back stage register plus GPR write-data mux.
// Captures the MEM-stage fields each cycle (1-cycle latency) with priority
// reset > flush > stall > load, and presents the GPR write port.
// Configuration: define WB_LOAD_EXT_EN to enable sub-word load extension;
// otherwise memory write data is the raw memory word for every load type.
// Ports:
//   clk, reset (sync, active-high), stall, flush
//   m_valid, m_regwrite, m_wa[4:0], m_wdsel[1:0], m_pc[31:0], m_alu[31:0],
//   m_memrd[31:0], m_ldtype[2:0], m_addr_lo[1:0]  -- MEM-stage inputs
//   grf_we, grf_wa[4:0], grf_wd[31:0], grf_wpc[31:0] -- GPR write port
//   w_valid -- W stage holds a real instruction
// -----------------------------------------------------------------------------
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = WB_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        m_valid,
  input  logic        m_regwrite,
  input  logic [4:0]  m_wa,
  input  logic [1:0]  m_wdsel,
  input  logic [31:0] m_pc,
  input  logic [31:0] m_alu,
  input  logic [31:0] m_memrd,
  input  logic [2:0]  m_ldtype,
  input  logic [1:0]  m_addr_lo,
  output logic        grf_we,
  output logic [4:0]  grf_wa,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_wpc,
  output logic        w_valid
);

  logic        r_valid;
  logic        r_regwrite;
  logic [4:0]  r_wa;
  logic [1:0]  r_wdsel;
  logic [31:0] r_pc;
  logic [31:0] r_alu;
  logic [31:0] r_memrd;
  logic [2:0]  r_ldtype;
  logic [1:0]  r_addr_lo;
  logic [31:0] w_mem_data;

  // W-stage pipeline register: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_wa       <= 5'd0;
      r_wdsel    <= 2'b00;
      r_pc       <= RESET_PC;
      r_alu      <= 32'h0000_0000;
      r_memrd    <= 32'h0000_0000;
      r_ldtype   <= 3'b000;
      r_addr_lo  <= 2'b00;
    end else if (flush) begin
      // Bubble: only the fields that can cause a GPR write are cleared;
      // the PC is kept so the stage still reports a meaningful address.
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_wa       <= 5'd0;
    end else if (!stall) begin
      r_valid    <= m_valid;
      r_regwrite <= m_regwrite;
      r_wa       <= m_wa;
      r_wdsel    <= m_wdsel;
      r_pc       <= m_pc;
      r_alu      <= m_alu;
      r_memrd    <= m_memrd;
      r_ldtype   <= m_ldtype;
      r_addr_lo  <= m_addr_lo;
    end
  end

`ifdef WB_LOAD_EXT_EN
  load_ext u_load_ext (
    .i_word   (r_memrd),
    .i_offset (r_addr_lo),
    .i_type   (r_ldtype),
    .o_data   (w_mem_data)
  );
`else
  // Without extension the raw word is written; load type and offset are
  // still captured so the stage state is identical in both builds.
  logic w_unused_ld;
  assign w_unused_ld = ^{r_ldtype, r_addr_lo};
  assign w_mem_data  = r_memrd;
`endif

  // GPR write-data source mux, fed only from registered fields
  always_comb begin
    grf_wd = 32'h0000_0000;
    case (r_wdsel)
      WDSEL_ALU:  grf_wd = r_alu;
      WDSEL_MEM:  grf_wd = w_mem_data;
      WDSEL_PC8:  grf_wd = r_pc + 32'd8;   // wraps mod 2^32
      WDSEL_ZERO: grf_wd = 32'h0000_0000;
      default:    grf_wd = 32'h0000_0000;
    endcase
  end

  // Writes to register 0 are suppressed here so the GPR file need not care
  assign grf_we  = r_valid & r_regwrite & (r_wa != 5'd0);
  assign grf_wa  = r_wa;
  assign grf_wpc = r_pc;
  assign w_valid = r_valid;

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Directed self-checking bench for wb_stage. Expected values are hand-derived
// constants; load-extension expectations follow the WB_LOAD_EXT_EN build.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        m_valid;
  logic        m_regwrite;
  logic [4:0]  m_wa;
  logic [1:0]  m_wdsel;
  logic [31:0] m_pc;
  logic [31:0] m_alu;
  logic [31:0] m_memrd;
  logic [2:0]  m_ldtype;
  logic [1:0]  m_addr_lo;
  logic        grf_we;
  logic [4:0]  grf_wa;
  logic [31:0] grf_wd;
  logic [31:0] grf_wpc;
  logic        w_valid;

  int checks;
  int errors;

  wb_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_regwrite (m_regwrite),
    .m_wa       (m_wa),
    .m_wdsel    (m_wdsel),
    .m_pc       (m_pc),
    .m_alu      (m_alu),
    .m_memrd    (m_memrd),
    .m_ldtype   (m_ldtype),
    .m_addr_lo  (m_addr_lo),
    .grf_we     (grf_we),
    .grf_wa     (grf_wa),
    .grf_wd     (grf_wd),
    .grf_wpc    (grf_wpc),
    .w_valid    (w_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] wa,
                       input logic [1:0] sel, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] rd,
                       input logic [2:0] lt, input logic [1:0] off);
    m_valid = v; m_regwrite = rw; m_wa = wa; m_wdsel = sel; m_pc = pc;
    m_alu = alu; m_memrd = rd; m_ldtype = lt; m_addr_lo = off;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 5'd17, 2'b00, 32'hDEAD_BEEC, 32'h5555_AAAA,
          32'h1111_2222, 3'b010, 2'b11);
    reset = 1'b1;
    tick();
    tick();
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", grf_we); end
    checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", w_valid); end
    checks++; if (grf_wa !== 5'd0) begin errors++; $display("FAIL reset_wa: got %0d expected 0", grf_wa); end
    checks++; if (grf_wpc !== 32'h0000_3000) begin errors++; $display("FAIL reset_wpc: got %h expected 00003000", grf_wpc); end
    checks++; if (grf_wd !== 32'h0000_0000) begin errors++; $display("FAIL reset_wd: got %h expected 00000000", grf_wd); end
    reset = 1'b0;
  endtask

  task automatic test_alu_path();
    drive(1'b1, 1'b1, 5'd8, 2'b00, 32'h0000_3004, 32'h1234_5678,
          32'hFFFF_FFFF, 3'b000, 2'b00);
    tick();
    checks++; if (grf_we !== 1'b1) begin errors++; $display("FAIL alu_we: got %b expected 1", grf_we); end
    checks++; if (w_valid !== 1'b1) begin errors++; $display("FAIL alu_valid: got %b expected 1", w_valid); end
    checks++; if (grf_wa !== 5'd8) begin errors++; $display("FAIL alu_wa: got %0d expected 8", grf_wa); end
    checks++; if (grf_wd !== 32'h1234_5678) begin errors++; $display("FAIL alu_wd: got %h expected 12345678", grf_wd); end
    checks++; if (grf_wpc !== 32'h0000_3004) begin errors++; $display("FAIL alu_wpc: got %h expected 00003004", grf_wpc); end
  endtask

  task automatic test_load_path();
    logic [2:0]  lt  [12];
    logic [1:0]  off [12];
    logic [31:0] exp_ext [12];
    logic [31:0] exp_wd;
    lt[0]  = 3'b010; off[0]  = 2'd3; exp_ext[0]  = 32'hFFFF_FF80; // lb
    lt[1]  = 3'b001; off[1]  = 2'd3; exp_ext[1]  = 32'h0000_0080; // lbu
    lt[2]  = 3'b100; off[2]  = 2'd2; exp_ext[2]  = 32'hFFFF_80FF; // lh
    lt[3]  = 3'b011; off[3]  = 2'd1; exp_ext[3]  = 32'h0000_7F01; // lhu
    lt[4]  = 3'b010; off[4]  = 2'd1; exp_ext[4]  = 32'h0000_007F; // lb
    lt[5]  = 3'b001; off[5]  = 2'd2; exp_ext[5]  = 32'h0000_00FF; // lbu
    lt[6]  = 3'b100; off[6]  = 2'd3; exp_ext[6]  = 32'hFFFF_80FF; // lh, bit0 ignored
    lt[7]  = 3'b011; off[7]  = 2'd2; exp_ext[7]  = 32'h0000_80FF; // lhu
    lt[8]  = 3'b100; off[8]  = 2'd0; exp_ext[8]  = 32'h0000_7F01; // lh positive
    lt[9]  = 3'b000; off[9]  = 2'd3; exp_ext[9]  = 32'h80FF_7F01; // lw ignores offset
    lt[10] = 3'b111; off[10] = 2'd2; exp_ext[10] = 32'h80FF_7F01; // reserved -> lw
    lt[11] = 3'b101; off[11] = 2'd3; exp_ext[11] = 32'h80FF_7F01; // reserved -> lw
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, 5'd5, 2'b01, 32'h0000_3100 + 32'(i * 4),
            32'h0BAD_0BAD, 32'h80FF_7F01, lt[i], off[i]);
      tick();
`ifdef WB_LOAD_EXT_EN
      exp_wd = exp_ext[i];
`else
      exp_wd = 32'h80FF_7F01;
`endif
      checks++;
      if (grf_wd !== exp_wd) begin
        errors++;
        $display("FAIL load_wd[%0d] type=%b off=%0d: got %h expected %h",
                 i, lt[i], off[i], grf_wd, exp_wd);
      end
    end
  endtask

  task automatic test_pc8_and_zero();
    drive(1'b1, 1'b1, 5'd31, 2'b10, 32'hFFFF_FFFC, 32'h7777_7777,
          32'h6666_6666, 3'b000, 2'b00);
    tick();
    checks++; if (grf_wd !== 32'h0000_0004) begin errors++; $display("FAIL pc8_wd: got %h expected 00000004", grf_wd); end
    checks++; if (grf_we !== 1'b1) begin errors++; $display("FAIL pc8_we: got %b expected 1", grf_we); end
    checks++; if (grf_wa !== 5'd31) begin errors++; $display("FAIL pc8_wa: got %0d expected 31", grf_wa); end
    drive(1'b1, 1'b1, 5'd3, 2'b10, 32'h0000_3200, 32'h7777_7777,
          32'h6666_6666, 3'b000, 2'b00);
    tick();
    checks++; if (grf_wd !== 32'h0000_3208) begin errors++; $display("FAIL pc8b_wd: got %h expected 00003208", grf_wd); end
    drive(1'b1, 1'b1, 5'd3, 2'b11, 32'h0000_3204, 32'h7777_7777,
          32'h6666_6666, 3'b000, 2'b00);
    tick();
    checks++; if (grf_wd !== 32'h0000_0000) begin errors++; $display("FAIL zero_wd: got %h expected 00000000", grf_wd); end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 1'b1, 5'd9, 2'b00, 32'h0000_3010, 32'hAAAA_5555,
          32'h0000_0000, 3'b000, 2'b00);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 5'd20 + 5'(i), 2'b10, 32'h0000_4000 + 32'(i),
            32'h1357_9BDF, 32'h2468_ACE0, 3'b010, 2'b01);
      tick();
      checks++;
      if ({grf_we, w_valid, grf_wa, grf_wd, grf_wpc} !==
          {1'b1, 1'b1, 5'd9, 32'hAAAA_5555, 32'h0000_3010}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got we=%b v=%b wa=%0d wd=%h wpc=%h expected we=1 v=1 wa=9 wd=aaaa5555 wpc=00003010",
                 i, grf_we, w_valid, grf_wa, grf_wd, grf_wpc);
      end
    end
    drive(1'b1, 1'b1, 5'd21, 2'b00, 32'h0000_5000, 32'h1357_9BDF,
          32'h0, 3'b000, 2'b00);
    flush = 1'b1;
    tick();
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL flush_we: got %b expected 0", grf_we); end
    checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", w_valid); end
    checks++; if (grf_wa !== 5'd0) begin errors++; $display("FAIL flush_wa: got %0d expected 0", grf_wa); end
    checks++; if (grf_wpc !== 32'h0000_3010) begin errors++; $display("FAIL flush_wpc: got %h expected 00003010", grf_wpc); end
    flush = 1'b0;
    stall = 1'b0;
    // Pipeline resumes loading after the bubble
    drive(1'b1, 1'b1, 5'd14, 2'b00, 32'h0000_3014, 32'h0F0F_0F0F,
          32'h0, 3'b000, 2'b00);
    tick();
    checks++; if ({grf_we, grf_wa, grf_wd} !== {1'b1, 5'd14, 32'h0F0F_0F0F}) begin errors++; $display("FAIL resume: got we=%b wa=%0d wd=%h expected we=1 wa=14 wd=0f0f0f0f", grf_we, grf_wa, grf_wd); end
  endtask

  task automatic test_write_gating();
    drive(1'b1, 1'b1, 5'd0, 2'b00, 32'h0000_3020, 32'h0000_00FF,
          32'h0, 3'b000, 2'b00);
    tick();
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL r0_we: got %b expected 0", grf_we); end
    checks++; if (w_valid !== 1'b1) begin errors++; $display("FAIL r0_valid: got %b expected 1", w_valid); end
    drive(1'b0, 1'b1, 5'd7, 2'b00, 32'h0000_3024, 32'h0000_00FF,
          32'h0, 3'b000, 2'b00);
    tick();
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL invalid_we: got %b expected 0", grf_we); end
    checks++; if (grf_wa !== 5'd7) begin errors++; $display("FAIL invalid_wa: got %0d expected 7", grf_wa); end
    drive(1'b1, 1'b0, 5'd7, 2'b00, 32'h0000_3028, 32'h0000_00FF,
          32'h0, 3'b000, 2'b00);
    tick();
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL noregwrite_we: got %b expected 0", grf_we); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 1'b1, 5'd12, 2'b00, 32'h0000_3030, 32'hCAFE_F00D,
          32'h0, 3'b000, 2'b00);
    tick();
    stall = 1'b1;
    reset = 1'b1;
    tick();
    checks++;
    if ({grf_we, w_valid, grf_wa, grf_wd, grf_wpc} !==
        {1'b0, 1'b0, 5'd0, 32'h0000_0000, 32'h0000_3000}) begin
      errors++;
      $display("FAIL reset_stall: got we=%b v=%b wa=%0d wd=%h wpc=%h expected we=0 v=0 wa=0 wd=00000000 wpc=00003000",
               grf_we, w_valid, grf_wa, grf_wd, grf_wpc);
    end
    reset = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    stall  = 1'b0;
    flush  = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00);
    test_reset();
    test_alu_path();
    test_load_path();
    test_pc8_and_zero();
    test_stall_flush();
    test_write_gating();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_3000, value held in the write-back PC register after reset.
REQ-002 Port: clk  in  1  clock, all state on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: stall  in  1  hold W-stage register contents.
REQ-005 Port: flush  in  1  load a bubble into the W stage.
REQ-006 Port: m_valid  in  1  MEM stage holds a real instruction.
REQ-007 Port: m_regwrite  in  1  instruction writes the GPR file.
REQ-008 Port: m_wa  in  5  destination register number.
REQ-009 Port: m_wdsel  in  2  write-data source: 00 ALU, 01 memory, 10 PC+8, 11 zero.
REQ-010 Port: m_pc  in  32  instruction PC.
REQ-011 Port: m_alu  in  32  ALU result.
REQ-012 Port: m_memrd  in  32  raw data-memory word.
REQ-013 Port: m_ldtype  in  3  000 lw, 001 lbu, 010 lb, 011 lhu, 100 lh.
REQ-014 Port: m_addr_lo  in  2  byte offset of the load address.
REQ-015 Ports out to the GPR file: grf_we 1, grf_wa 5, grf_wd 32, grf_wpc 32; plus w_valid 1, which is high when the W stage holds a real instruction.

Function
REQ-016 The block SHALL register all m_* inputs on a clock edge when reset=0, flush=0 and stall=0, giving 1-cycle latency from MEM to write-back outputs.
REQ-017 Priority SHALL be reset > flush > stall > load.
REQ-018 On flush, the block SHALL clear valid, regwrite and wa to 0 and keep the held PC value.
REQ-019 On stall without flush, every register SHALL hold its value.
REQ-020 grf_we SHALL equal valid_q & regwrite_q & (wa_q != 0).
REQ-021 grf_wa and grf_wpc SHALL come directly from registers; grf_wd SHALL be combinational from registered fields only.
REQ-022 wdsel 10 SHALL give pc_q+8, truncated mod 2^32.
REQ-023 wdsel 11 SHALL give 0.
REQ-024 Load byte select SHALL be memrd[8*addr_lo +: 8].
REQ-025 Load halfword select SHALL be memrd[16*addr_lo[1] +: 16], ignoring addr_lo[0].
REQ-026 lb and lh SHALL sign-extend; lbu and lhu SHALL zero-extend.
REQ-027 ldtype codes 101-111 SHALL be treated as lw.
REQ-028 lw SHALL ignore addr_lo.
REQ-029 When flush and stall are asserted together, flush SHALL win.
REQ-030 When m_valid=0 is loaded, grf_we SHALL be 0 for that cycle regardless of m_regwrite.

Reset
REQ-031 Reset SHALL set these to 0: valid, regwrite, wa, wdsel, alu, memrd, ldtype and addr_lo.
REQ-032 Reset SHALL set pc_q to RESET_PC.
REQ-033 Resulting outputs the cycle after reset: grf_we=0, grf_wa=0, w_valid=0, grf_wpc=RESET_PC, grf_wd=0.
REQ-034 Reset asserted mid-stall SHALL discard the held instruction.

Configuration
REQ-035 Macro WB_LOAD_EXT_EN defined: sub-word load extension per REQ-024 to REQ-028.
REQ-036 Macro WB_LOAD_EXT_EN undefined: memory write data SHALL be m_memrd unmodified for every ldtype, and no extension logic SHALL be instantiated.

Structure
REQ-037 A shared package SHALL hold the wdsel codes, the ldtype codes and the RESET_PC default.
REQ-038 Sub-module load_ext SHALL be combinational, with inputs word, offset and type, output 32-bit extended data; it SHALL be instantiated only under WB_LOAD_EXT_EN.

Verification
REQ-039 Reset scenario: reset for 2 cycles -> grf_we=0, w_valid=0, grf_wpc=32'h0000_3000, grf_wd=0.
REQ-040 ALU path: load m_regwrite=1, wa=8, wdsel=00, alu=32'h1234_5678, pc=32'h3004 -> next cycle grf_we=1, grf_wa=8, grf_wd=32'h1234_5678, grf_wpc=32'h3004.
REQ-041 Load path: memrd=32'h80FF_7F01 -> expected grf_wd:
- lb, offset 3: 32'hFFFF_FF80
- lbu, offset 3: 32'h0000_0080
- lh, offset 2: 32'hFFFF_80FF
- lhu, offset 1: 32'h0000_7F01
- with macro undefined, all cases: 32'h80FF_7F01
REQ-042 PC+8 path: wdsel=10, pc=32'hFFFF_FFFC, wa=31 -> grf_wd=32'h0000_0004, grf_we=1.
REQ-043 Stall and flush: stall for 3 cycles while m_* changes -> outputs unchanged; then flush together with stall -> grf_we=0, w_valid=0, grf_wa=0, grf_wpc unchanged.
REQ-044 Write to $0: load with wa=0, regwrite=1, valid=1 -> grf_we=0.
